// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle for the ID/EX stage: decoded fields and controls in,
// forwarding sources in, ALU operands and registered EX controls out.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      ID_VALID;
  logic [DATA_WIDTH-1:0]     ID_RS_DATA;
  logic [DATA_WIDTH-1:0]     ID_RT_DATA;
  logic [DATA_WIDTH-1:0]     ID_IMM;
  logic [REG_ADDR_WIDTH-1:0] ID_RS;
  logic [REG_ADDR_WIDTH-1:0] ID_RT;
  logic [REG_ADDR_WIDTH-1:0] ID_RD;
  logic [2:0]                ID_ALU_CONTROL;
  logic                      ID_ALU_SRC;
  logic                      ID_REG_DST;
  logic                      ID_REG_WRITE;
  logic                      ID_MEM_READ;
  logic                      ID_MEM_WRITE;
  logic                      ID_MEM_TO_REG;
  logic                      FLUSH;
  logic                      EXMEM_REG_WRITE;
  logic [REG_ADDR_WIDTH-1:0] EXMEM_RD;
  logic [DATA_WIDTH-1:0]     EXMEM_RESULT;
  logic                      MEMWB_REG_WRITE;
  logic [REG_ADDR_WIDTH-1:0] MEMWB_RD;
  logic [DATA_WIDTH-1:0]     MEMWB_RESULT;
  logic                      STALL;
  logic [DATA_WIDTH-1:0]     ALU_INPUT_1;
  logic [DATA_WIDTH-1:0]     ALU_INPUT_2;
  logic [2:0]                ALU_CONTROL;
  logic [DATA_WIDTH-1:0]     EX_STORE_DATA;
  logic [REG_ADDR_WIDTH-1:0] EX_WRITE_REG;
  logic                      EX_VALID;
  logic                      EX_REG_WRITE;
  logic                      EX_MEM_READ;
  logic                      EX_MEM_WRITE;
  logic                      EX_MEM_TO_REG;

  modport slave (
    input  ID_VALID, ID_RS_DATA, ID_RT_DATA, ID_IMM, ID_RS, ID_RT, ID_RD,
           ID_ALU_CONTROL, ID_ALU_SRC, ID_REG_DST, ID_REG_WRITE, ID_MEM_READ,
           ID_MEM_WRITE, ID_MEM_TO_REG, FLUSH,
           EXMEM_REG_WRITE, EXMEM_RD, EXMEM_RESULT,
           MEMWB_REG_WRITE, MEMWB_RD, MEMWB_RESULT,
    output STALL, ALU_INPUT_1, ALU_INPUT_2, ALU_CONTROL, EX_STORE_DATA,
           EX_WRITE_REG, EX_VALID, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE,
           EX_MEM_TO_REG
  );

  modport master (
    output ID_VALID, ID_RS_DATA, ID_RT_DATA, ID_IMM, ID_RS, ID_RT, ID_RD,
           ID_ALU_CONTROL, ID_ALU_SRC, ID_REG_DST, ID_REG_WRITE, ID_MEM_READ,
           ID_MEM_WRITE, ID_MEM_TO_REG, FLUSH,
           EXMEM_REG_WRITE, EXMEM_RD, EXMEM_RESULT,
           MEMWB_REG_WRITE, MEMWB_RD, MEMWB_RESULT,
    input  STALL, ALU_INPUT_1, ALU_INPUT_2, ALU_CONTROL, EX_STORE_DATA,
           EX_WRITE_REG, EX_VALID, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE,
           EX_MEM_TO_REG
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection (one-cycle stall plus bubble into EX).
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic          CLK,
  input logic          RESET,
  id_ex_stage_if.slave bus
);

  logic signed [DATA_WIDTH-1:0] r_rs_data_p1;
  logic signed [DATA_WIDTH-1:0] r_rt_data_p1;
  logic signed [DATA_WIDTH-1:0] r_imm_p1;
  logic [REG_ADDR_WIDTH-1:0]    r_rs_p1;
  logic [REG_ADDR_WIDTH-1:0]    r_rt_p1;
  logic [REG_ADDR_WIDTH-1:0]    r_write_reg_p1;
  logic [2:0]                   r_alu_control_p1;
  logic                         r_alu_src_p1;
  logic                         r_vld_p1;
  logic                         r_reg_write_p1;
  logic                         r_mem_read_p1;
  logic                         r_mem_write_p1;
  logic                         r_mem_to_reg_p1;

  logic                         w_stall;
  logic                         w_load;
  logic                         w_ctl_en;
  logic signed [DATA_WIDTH-1:0] w_opnd_a;
  logic signed [DATA_WIDTH-1:0] w_opnd_b;

  // $0 is hard-wired, so a write to it must never be forwarded.
  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [REG_ADDR_WIDTH-1:0] src,
    input logic [DATA_WIDTH-1:0]     latched,
    input logic                      em_we,
    input logic [REG_ADDR_WIDTH-1:0] em_rd,
    input logic [DATA_WIDTH-1:0]     em_res,
    input logic                      mw_we,
    input logic [REG_ADDR_WIDTH-1:0] mw_rd,
    input logic [DATA_WIDTH-1:0]     mw_res
  );
    if (em_we && (em_rd != '0) && (em_rd == src))      return em_res;
    else if (mw_we && (mw_rd != '0) && (mw_rd == src)) return mw_res;
    else                                               return latched;
  endfunction

  // Load-use hazard: rs and rt are both compared even when rt is not a source.
  assign w_stall = !RESET && r_vld_p1 && r_mem_read_p1 && bus.ID_VALID &&
                   (r_write_reg_p1 != '0) &&
                   ((r_write_reg_p1 == bus.ID_RS) || (r_write_reg_p1 == bus.ID_RT));
  assign w_load   = !bus.FLUSH && !w_stall;
  assign w_ctl_en = w_load && bus.ID_VALID;

  // ---- ID -> EX register (p1) ----
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_vld_p1         <= 1'b0;
      r_reg_write_p1   <= 1'b0;
      r_mem_read_p1    <= 1'b0;
      r_mem_write_p1   <= 1'b0;
      r_mem_to_reg_p1  <= 1'b0;
      r_alu_src_p1     <= 1'b0;
      r_alu_control_p1 <= 3'b000;
      r_write_reg_p1   <= '0;
      r_rs_p1          <= '0;
      r_rt_p1          <= '0;
      r_rs_data_p1     <= '0;
      r_rt_data_p1     <= '0;
      r_imm_p1         <= '0;
    end else begin
      r_vld_p1         <= w_load && bus.ID_VALID;
      r_reg_write_p1   <= w_ctl_en && bus.ID_REG_WRITE;
      r_mem_read_p1    <= w_ctl_en && bus.ID_MEM_READ;
      r_mem_write_p1   <= w_ctl_en && bus.ID_MEM_WRITE;
      r_mem_to_reg_p1  <= w_ctl_en && bus.ID_MEM_TO_REG;
      r_alu_src_p1     <= w_load && bus.ID_ALU_SRC;
      r_alu_control_p1 <= w_load ? bus.ID_ALU_CONTROL : 3'b000;
      r_write_reg_p1   <= !w_load ? '0 : (bus.ID_REG_DST ? bus.ID_RD : bus.ID_RT);
      r_rs_p1          <= w_load ? bus.ID_RS : '0;
      r_rt_p1          <= w_load ? bus.ID_RT : '0;
      r_rs_data_p1     <= w_load ? bus.ID_RS_DATA : '0;
      r_rt_data_p1     <= w_load ? bus.ID_RT_DATA : '0;
      r_imm_p1         <= w_load ? bus.ID_IMM : '0;
    end
  end

  // ---- EX operand select (combinational from p1) ----
  assign w_opnd_a = fwd(r_rs_p1, r_rs_data_p1,
                        bus.EXMEM_REG_WRITE, bus.EXMEM_RD, bus.EXMEM_RESULT,
                        bus.MEMWB_REG_WRITE, bus.MEMWB_RD, bus.MEMWB_RESULT);
  assign w_opnd_b = fwd(r_rt_p1, r_rt_data_p1,
                        bus.EXMEM_REG_WRITE, bus.EXMEM_RD, bus.EXMEM_RESULT,
                        bus.MEMWB_REG_WRITE, bus.MEMWB_RD, bus.MEMWB_RESULT);

  assign bus.STALL         = w_stall;
  assign bus.ALU_INPUT_1   = w_opnd_a;
  assign bus.ALU_INPUT_2   = r_alu_src_p1 ? r_imm_p1 : w_opnd_b;
  assign bus.EX_STORE_DATA = w_opnd_b;
  assign bus.ALU_CONTROL   = r_alu_control_p1;
  assign bus.EX_WRITE_REG  = r_write_reg_p1;
  assign bus.EX_VALID      = r_vld_p1;
  assign bus.EX_REG_WRITE  = r_reg_write_p1;
  assign bus.EX_MEM_READ   = r_mem_read_p1;
  assign bus.EX_MEM_WRITE  = r_mem_write_p1;
  assign bus.EX_MEM_TO_REG = r_mem_to_reg_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, operand select, forwarding priority,
// load-use stall/bubble, flush and reset during a stall.
module tb_id_ex_stage;

  logic CLK;
  logic RESET;
  int   vectors;
  int   miscompares;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ID_VALID        = 1'b0;
    bus.ID_RS_DATA      = '0;
    bus.ID_RT_DATA      = '0;
    bus.ID_IMM          = '0;
    bus.ID_RS           = '0;
    bus.ID_RT           = '0;
    bus.ID_RD           = '0;
    bus.ID_ALU_CONTROL  = 3'b000;
    bus.ID_ALU_SRC      = 1'b0;
    bus.ID_REG_DST      = 1'b0;
    bus.ID_REG_WRITE    = 1'b0;
    bus.ID_MEM_READ     = 1'b0;
    bus.ID_MEM_WRITE    = 1'b0;
    bus.ID_MEM_TO_REG   = 1'b0;
    bus.FLUSH           = 1'b0;
    bus.EXMEM_REG_WRITE = 1'b0;
    bus.EXMEM_RD        = '0;
    bus.EXMEM_RESULT    = '0;
    bus.MEMWB_REG_WRITE = 1'b0;
    bus.MEMWB_RD        = '0;
    bus.MEMWB_RESULT    = '0;
  endtask

  task automatic drive_lw_to_r8();
    clear_inputs();
    bus.ID_VALID       = 1'b1;
    bus.ID_RS          = 5'd2;
    bus.ID_RT          = 5'd8;
    bus.ID_IMM         = 32'd4;
    bus.ID_ALU_SRC     = 1'b1;
    bus.ID_ALU_CONTROL = 3'b010;
    bus.ID_REG_WRITE   = 1'b1;
    bus.ID_MEM_READ    = 1'b1;
    bus.ID_MEM_TO_REG  = 1'b1;
  endtask

  task automatic drive_add_uses_r8();
    clear_inputs();
    bus.ID_VALID       = 1'b1;
    bus.ID_RS          = 5'd8;
    bus.ID_RT          = 5'd9;
    bus.ID_RD          = 5'd10;
    bus.ID_REG_DST     = 1'b1;
    bus.ID_RS_DATA     = 32'h0000_DEAD;
    bus.ID_RT_DATA     = 32'd3;
    bus.ID_ALU_CONTROL = 3'b010;
    bus.ID_REG_WRITE   = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clear_inputs();
    RESET = 1'b1;
    #12;
    RESET = 1'b0;
    #1;

    // Plain add
    bus.ID_VALID       = 1'b1;
    bus.ID_RS_DATA     = 32'd5;
    bus.ID_RT_DATA     = 32'd7;
    bus.ID_RS          = 5'd1;
    bus.ID_RT          = 5'd2;
    bus.ID_RD          = 5'd3;
    bus.ID_ALU_CONTROL = 3'b010;
    bus.ID_REG_DST     = 1'b1;
    bus.ID_REG_WRITE   = 1'b1;
    step();
    chk("add_op1",   bus.ALU_INPUT_1, 32'd5);
    chk("add_op2",   bus.ALU_INPUT_2, 32'd7);
    chk("add_wreg",  32'(bus.EX_WRITE_REG), 32'd3);
    chk("add_valid", 32'(bus.EX_VALID), 32'd1);
    chk("add_ctl",   32'(bus.ALU_CONTROL), 32'd2);
    chk("add_regwr", 32'(bus.EX_REG_WRITE), 32'd1);
    chk("add_stall", 32'(bus.STALL), 32'd0);

    // Asynchronous reset between edges
    #3;
    RESET = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.EX_VALID), 32'd0);
    chk("rst_op1",   bus.ALU_INPUT_1, 32'd0);
    chk("rst_op2",   bus.ALU_INPUT_2, 32'd0);
    chk("rst_ctl",   32'(bus.ALU_CONTROL), 32'd0);
    chk("rst_wreg",  32'(bus.EX_WRITE_REG), 32'd0);
    chk("rst_regwr", 32'(bus.EX_REG_WRITE), 32'd0);
    chk("rst_stall", 32'(bus.STALL), 32'd0);
    RESET = 1'b0;

    // Immediate select, destination = rt
    clear_inputs();
    bus.ID_VALID       = 1'b1;
    bus.ID_RS_DATA     = 32'h10;
    bus.ID_RT_DATA     = 32'd9;
    bus.ID_IMM         = 32'hFFFF_FFFC;
    bus.ID_RS          = 5'd1;
    bus.ID_RT          = 5'd6;
    bus.ID_RD          = 5'd12;
    bus.ID_ALU_SRC     = 1'b1;
    bus.ID_ALU_CONTROL = 3'b010;
    bus.ID_REG_WRITE   = 1'b1;
    step();
    chk("imm_op1",   bus.ALU_INPUT_1, 32'h10);
    chk("imm_op2",   bus.ALU_INPUT_2, 32'hFFFF_FFFC);
    chk("imm_store", bus.EX_STORE_DATA, 32'd9);
    chk("imm_wreg",  32'(bus.EX_WRITE_REG), 32'd6);

    // Forwarding priority
    clear_inputs();
    bus.ID_VALID       = 1'b1;
    bus.ID_RS          = 5'd4;
    bus.ID_RT          = 5'd5;
    bus.ID_RS_DATA     = 32'h33;
    bus.ID_RT_DATA     = 32'h44;
    bus.ID_ALU_CONTROL = 3'b110;
    step();
    bus.EXMEM_REG_WRITE = 1'b1;
    bus.EXMEM_RD        = 5'd4;
    bus.EXMEM_RESULT    = 32'h11;
    bus.MEMWB_REG_WRITE = 1'b1;
    bus.MEMWB_RD        = 5'd4;
    bus.MEMWB_RESULT    = 32'h22;
    #1;
    chk("fwd_both_op1", bus.ALU_INPUT_1, 32'h11);
    chk("fwd_both_op2", bus.ALU_INPUT_2, 32'h44);
    chk("fwd_ctl",      32'(bus.ALU_CONTROL), 32'd6);
    bus.EXMEM_REG_WRITE = 1'b0;
    #1;
    chk("fwd_memwb_op1", bus.ALU_INPUT_1, 32'h22);
    bus.EXMEM_REG_WRITE = 1'b1;
    bus.MEMWB_RD        = 5'd5;
    #1;
    chk("fwd_split_op1",   bus.ALU_INPUT_1, 32'h11);
    chk("fwd_split_op2",   bus.ALU_INPUT_2, 32'h22);
    chk("fwd_split_store", bus.EX_STORE_DATA, 32'h22);

    // Register $0 is never forwarded
    clear_inputs();
    bus.ID_VALID   = 1'b1;
    bus.ID_RS      = 5'd0;
    bus.ID_RT      = 5'd0;
    bus.ID_RS_DATA = 32'h55;
    bus.ID_RT_DATA = 32'h66;
    step();
    bus.EXMEM_REG_WRITE = 1'b1;
    bus.EXMEM_RD        = 5'd0;
    bus.EXMEM_RESULT    = 32'h11;
    bus.MEMWB_REG_WRITE = 1'b1;
    bus.MEMWB_RD        = 5'd0;
    bus.MEMWB_RESULT    = 32'h22;
    #1;
    chk("r0_op1", bus.ALU_INPUT_1, 32'h55);
    chk("r0_op2", bus.ALU_INPUT_2, 32'h66);

    // Invalid decode latches controls as 0
    clear_inputs();
    bus.ID_VALID     = 1'b0;
    bus.ID_REG_WRITE = 1'b1;
    bus.ID_MEM_WRITE = 1'b1;
    step();
    chk("inv_valid", 32'(bus.EX_VALID), 32'd0);
    chk("inv_regwr", 32'(bus.EX_REG_WRITE), 32'd0);
    chk("inv_memwr", 32'(bus.EX_MEM_WRITE), 32'd0);

    // Load-use: lw $8 in EX, add reading $8 in decode
    drive_lw_to_r8();
    step();
    drive_add_uses_r8();
    #1;
    chk("lu_stall",   32'(bus.STALL), 32'd1);
    chk("lu_memrd",   32'(bus.EX_MEM_READ), 32'd1);
    chk("lu_lw_wreg", 32'(bus.EX_WRITE_REG), 32'd8);
    step();
    chk("lu_bub_valid", 32'(bus.EX_VALID), 32'd0);
    chk("lu_bub_regwr", 32'(bus.EX_REG_WRITE), 32'd0);
    chk("lu_bub_ctl",   32'(bus.ALU_CONTROL), 32'd0);
    chk("lu_bub_wreg",  32'(bus.EX_WRITE_REG), 32'd0);
    chk("lu_bub_stall", 32'(bus.STALL), 32'd0);
    step();
    bus.MEMWB_REG_WRITE = 1'b1;
    bus.MEMWB_RD        = 5'd8;
    bus.MEMWB_RESULT    = 32'h0000_CAFE;
    #1;
    chk("lu_add_valid", 32'(bus.EX_VALID), 32'd1);
    chk("lu_add_stall", 32'(bus.STALL), 32'd0);
    chk("lu_add_op1",   bus.ALU_INPUT_1, 32'h0000_CAFE);
    chk("lu_add_op2",   bus.ALU_INPUT_2, 32'd3);
    chk("lu_add_wreg",  32'(bus.EX_WRITE_REG), 32'd10);

    // Flush discards the decoded instruction
    clear_inputs();
    bus.ID_VALID       = 1'b1;
    bus.ID_RS_DATA     = 32'h77;
    bus.ID_RD          = 5'd7;
    bus.ID_REG_DST     = 1'b1;
    bus.ID_ALU_CONTROL = 3'b001;
    bus.ID_REG_WRITE   = 1'b1;
    bus.ID_MEM_WRITE   = 1'b1;
    bus.FLUSH          = 1'b1;
    step();
    chk("fl_valid", 32'(bus.EX_VALID), 32'd0);
    chk("fl_regwr", 32'(bus.EX_REG_WRITE), 32'd0);
    chk("fl_memwr", 32'(bus.EX_MEM_WRITE), 32'd0);
    chk("fl_ctl",   32'(bus.ALU_CONTROL), 32'd0);
    chk("fl_op1",   bus.ALU_INPUT_1, 32'd0);
    chk("fl_wreg",  32'(bus.EX_WRITE_REG), 32'd0);
    bus.FLUSH = 1'b0;

    // Reset during a stall drops STALL immediately
    drive_lw_to_r8();
    step();
    drive_add_uses_r8();
    #1;
    chk("rs_pre_stall", 32'(bus.STALL), 32'd1);
    RESET = 1'b1;
    #1;
    chk("rs_stall", 32'(bus.STALL), 32'd0);
    chk("rs_valid", 32'(bus.EX_VALID), 32'd0);
    chk("rs_memrd", 32'(bus.EX_MEM_READ), 32'd0);
    RESET = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
